// File: rtl/out_channel_fifo.sv
// out_channel_fifo
// Buffers words from the interpreter's `out` instruction and streams them to a
// downstream consumer over valid/ready. After programDone it drains and then
// raises the sticky drained flag.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   pushValid/pushData  word from the interpreter; pushReady = not full and RUN
//   popValid/popData    first-word fall-through head of the FIFO
//   popReady            consumer accepts the head word
//   programDone         interpreter finished (pulse or level)
//   count               words currently buffered (0..Depth)
//   wordsOut            total words popped since reset, wraps mod 2^16
//   overflow            sticky, a push was dropped
//   drained             sticky, program done and every word consumed
module out_channel_fifo #(
    parameter int unsigned MemoryElementWidth = 12,
    parameter int unsigned Depth              = 16,
    parameter int unsigned AddrWidth          = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          pushValid,
    input  logic [MemoryElementWidth-1:0] pushData,
    output logic                          pushReady,
    output logic                          popValid,
    output logic [MemoryElementWidth-1:0] popData,
    input  logic                          popReady,
    input  logic                          programDone,
    output logic [AddrWidth:0]            count,
    output logic [15:0]                   wordsOut,
    output logic                          overflow,
    output logic                          drained
);

    localparam int unsigned PtrWidth      = AddrWidth + 1;
    localparam int unsigned WordsOutWidth = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [MemoryElementWidth-1:0] r_mem [Depth];
    logic [PtrWidth-1:0]           r_wr_ptr;
    logic [PtrWidth-1:0]           r_rd_ptr;
    logic [WordsOutWidth-1:0]      r_words_out;
    logic                          r_overflow;
    state_t                        r_state;
    state_t                        w_state_next;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Pointer comparison: the extra MSB distinguishes full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AddrWidth-1:0] == r_rd_ptr[AddrWidth-1:0]) &&
                     (r_wr_ptr[AddrWidth] != r_rd_ptr[AddrWidth]);

    assign popValid = !w_empty;
    assign popData  = r_mem[r_rd_ptr[AddrWidth-1:0]];
    assign count    = r_wr_ptr - r_rd_ptr;
    assign wordsOut = r_words_out;
    assign overflow = r_overflow;

    assign w_push = pushValid && pushReady;
    assign w_drop = pushValid && !pushReady;
    assign w_pop  = popValid && popReady;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and state-derived outputs.
    always_comb begin
        w_state_next = r_state;
        pushReady    = 1'b0;
        drained      = 1'b0;
        case (r_state)
            ST_RUN: begin
                pushReady = !w_full;
                if (programDone) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Empty is judged on registered pointers, so DONE follows one
                // cycle after the last pop.
                if (w_empty) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                drained = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Storage write; contents need no reset since popValid masks them.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr[AddrWidth-1:0]] <= pushData;
        end
    end

    // Pointers, pop counter and sticky overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_words_out <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PtrWidth'(1);
                r_words_out <= r_words_out + WordsOutWidth'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_channel_fifo.sv
// Testbench for out_channel_fifo: directed scenarios plus randomized traffic,
// checked against a queue-based reference model and a data scoreboard.
module tb_out_channel_fifo;

    localparam int unsigned W     = 12;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clock;
    logic          reset;
    logic          pushValid;
    logic [W-1:0]  pushData;
    logic          pushReady;
    logic          popValid;
    logic [W-1:0]  popData;
    logic          popReady;
    logic          programDone;
    logic [AW:0]   count;
    logic [15:0]   wordsOut;
    logic          overflow;
    logic          drained;

    out_channel_fifo #(
        .MemoryElementWidth(W),
        .Depth(DEPTH),
        .AddrWidth(AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pushValid(pushValid),
        .pushData(pushData),
        .pushReady(pushReady),
        .popValid(popValid),
        .popData(popData),
        .popReady(popReady),
        .programDone(programDone),
        .count(count),
        .wordsOut(wordsOut),
        .overflow(overflow),
        .drained(drained)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = accepting, 1 = draining, 2 = finished.
    logic [W-1:0] exp_q[$];
    int           m_count = 0;
    int           m_phase = 0;
    int           m_words = 0;
    bit           m_ovf   = 0;
    bit           m_drained = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each edge, from the inputs the DUT also sees.
    always @(posedge clock) begin
        bit acc_push;
        bit do_pop;
        bit was_empty;
        if (reset) begin
            exp_q.delete();
            m_count   = 0;
            m_phase   = 0;
            m_words   = 0;
            m_ovf     = 0;
            m_drained = 0;
        end else begin
            acc_push  = pushValid && (m_count < DEPTH) && (m_phase == 0);
            do_pop    = popReady && (m_count > 0);
            was_empty = (m_count == 0);
            if (acc_push)
                exp_q.push_back(pushData);
            else if (pushValid)
                m_ovf = 1;
            m_count = m_count + int'(acc_push) - int'(do_pop);
            if (do_pop)
                m_words = (m_words + 1) % 65536;
            if (m_phase == 1 && was_empty) begin
                m_phase   = 2;
                m_drained = 1;
            end
            if (m_phase == 0 && programDone)
                m_phase = 1;
        end
    end

    // Monitor: sample away from the active edge, compare status and pop data.
    always @(negedge clock) begin
        if (!reset) begin
            chk("pushReady", 32'(pushReady), 32'((m_count < DEPTH) && (m_phase == 0)));
            chk("popValid",  32'(popValid),  32'(m_count > 0));
            chk("count",     32'(count),     32'(m_count));
            chk("wordsOut",  32'(wordsOut),  32'(m_words));
            chk("overflow",  32'(overflow),  32'(m_ovf));
            chk("drained",   32'(drained),   32'(m_drained));
            if (popValid === 1'b1 && popReady === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL popData: got %0d expected nothing (scoreboard empty) at %0t", popData, $time);
                end else begin
                    chk("popData", 32'(popData), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input logic pv, input int pd, input logic prd, input logic pdn);
        pushValid   = pv;
        pushData    = W'(pd);
        popReady    = prd;
        programDone = pdn;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        pushValid   = 1'b0;
        pushData    = '0;
        popReady    = 1'b0;
        programDone = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single word
        step(1, 2, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Fill to full, overflow, then drain in order
        for (int i = 1; i <= 16; i++) step(1, i, 0, 0);
        step(1, 17, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 0, 1, 0);

        // Wrap-around with back-to-back push/pop
        for (int i = 0; i < 40; i++) step(1, 100 + i, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Simultaneous push and pop at full
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 200 + i, 0, 0);
        step(1, 55, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0);

        // Randomized traffic: push-heavy then pop-heavy
        for (int i = 0; i < 150; i++)
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)), $urandom_range(0, 2) == 0, 0);
        for (int i = 0; i < 150; i++)
            step($urandom_range(0, 2) == 0, int'($urandom_range(0, 4095)), $urandom_range(0, 3) != 0, 0);

        // Drain sequence
        do_reset();
        step(1, 7, 0, 0);
        step(1, 8, 0, 0);
        step(1, 9, 0, 0);
        step(0, 0, 0, 1);
        step(1, 99, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        step(1, 5, 1, 0);

        // Reset mid-stream: count 5, overflow set, draining
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 300 + i, 0, 0);
        step(0, 0, 0, 1);
        step(1, 77, 0, 0);
        do_reset();
        step(1, 3, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Randomized traffic with occasional programDone
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 120; i++)
                step($urandom_range(0, 1) == 1, int'($urandom_range(0, 4095)),
                     $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
